// File: rtl/rand_txn_gen_if.sv
// rand_txn_gen_if: valid/ready beat stream carrying payload and end-of-burst marker
interface rand_txn_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    modport master (output out_valid, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/rand_txn_gen.sv
// rand_txn_gen: randomized burst source sliced from rand_vect; RAND_TXN_GEN_CHECKSUM_EN adds an XOR checksum of accepted beats
module rand_txn_gen #(
    parameter int RAND_WIDTH = 257,
    parameter int DATA_WIDTH = 32,
    parameter int GAP_BITS   = 4,
    parameter int BURST_BITS = 3,
    parameter int NUM_TXNS   = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RAND_WIDTH-1:0] rand_vect_i,
    input  logic                  enable_i,
    rand_txn_gen_if.master        out,
    output logic [CNT_WIDTH-1:0]  txn_count_o,
    output logic                  done_o
`ifdef RAND_TXN_GEN_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);
    localparam int FIELD_W = DATA_WIDTH + GAP_BITS + BURST_BITS;
    localparam bit CAPPED = NUM_TXNS != 0;
    localparam logic [CNT_WIDTH-1:0] CAP    = CNT_WIDTH'(NUM_TXNS);
    localparam logic [CNT_WIDTH-1:0] CAP_M1 = CNT_WIDTH'(NUM_TXNS - 1);

    generate
        if (RAND_WIDTH < FIELD_W) begin : g_width_chk
            $error("rand_txn_gen: RAND_WIDTH too small for data, gap and burst fields");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GAP, BURST, DONE} state_t;

    state_t                state_q, state_d;
    logic [GAP_BITS-1:0]   gap_q, gap_d;
    logic [BURST_BITS-1:0] beats_q, beats_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    logic [DATA_WIDTH-1:0] f_data;
    logic [GAP_BITS-1:0]   f_gap;
    logic [BURST_BITS-1:0] f_burst;
    logic                  hs;
    logic                  unused_rand;

    assign f_data      = rand_vect_i[DATA_WIDTH-1:0];
    assign f_gap       = rand_vect_i[DATA_WIDTH+:GAP_BITS];
    assign f_burst     = rand_vect_i[DATA_WIDTH+GAP_BITS+:BURST_BITS];
    assign unused_rand = ^rand_vect_i;
    assign hs          = valid_q && out.out_ready;

    assign out.out_valid = valid_q;
    assign out.out_data  = data_q;
    assign out.out_last  = last_q;
    assign txn_count_o   = count_q;
    assign done_o        = done_q;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
    assign checksum_o    = csum_q;
`endif

    // Next-state: burst sequencing, beat loading and the beat cap that forces an early last
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        beats_d = beats_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = done_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable_i && !done_q) begin
                    gap_d   = f_gap;
                    beats_d = f_burst;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    data_d  = f_data;
                    valid_d = 1'b1;
                    last_d  = (beats_q == '0) || (CAPPED && count_q == CAP_M1);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (hs) begin
                    count_d = count_q + 1'b1;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
                    csum_d  = csum_q ^ data_q;
`endif
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = CAPPED && count_d == CAP;
                        state_d = done_d ? DONE : IDLE;
                    end else begin
                        data_d  = f_data;
                        beats_d = beats_q - 1'b1;
                        last_d  = (beats_d == '0) || (CAPPED && count_d == CAP_M1);
                    end
                end
            end
            DONE: valid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any pending beat outright
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
            beats_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            beats_q <= beats_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_rand_txn_gen.sv
// tb_rand_txn_gen: scoreboard bench; bursts queued at issue, monitor checks timing, payload history, last, count and done
module tb_rand_txn_gen;
    localparam int RW = 64;
    localparam int DW = 32;
    localparam int NT = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic [RW-1:0] rand_vect = '0;
    logic [31:0]   txn_count;
    logic          done;
`ifdef RAND_TXN_GEN_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    rand_txn_gen_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.out_ready = ready;

    rand_txn_gen #(
        .RAND_WIDTH(RW), .DATA_WIDTH(DW), .GAP_BITS(4), .BURST_BITS(3), .NUM_TXNS(NT), .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rand_vect_i(rand_vect),
        .enable_i(enable),
        .out(bus),
        .txn_count_o(txn_count),
        .done_o(done)
`ifdef RAND_TXN_GEN_CHECKSUM_EN
        ,
        .checksum_o(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int t; int gap; int n;} exp_t;
    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] hist [int];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            issued = 0;
    int            rmode = 0;
    int            stall = 0;
    bit            fix_on = 0;
    logic [DW-1:0] fix_val = '0;
    bit            active = 0;
    bit            started = 0;
    int            idx = 0;
    int            nbeats = 0;
    int            mcount = 0;
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] mcsum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: each beat's payload is the data field present in the cycle it was loaded
    always @(negedge clk) begin
        hist[cyc] = rand_vect[DW-1:0];
        if (reset) begin
            sb.delete();
            active = 0;
            idx = 0;
            mcount = 0;
            mcsum = '0;
            started = 1;
        end else if (started) begin
            chk("txn_count", txn_count, mcount);
            chk("done", done, mcount == NT);
`ifdef RAND_TXN_GEN_CHECKSUM_EN
            chk("checksum", checksum, mcsum);
`endif
            if (bus.out_valid) begin
                if (!active) begin
                    if (sb.size() == 0) chk("spurious_valid", bus.out_valid, 0);
                    else begin
                        e = sb.pop_front();
                        chk("first_beat_cycle", cyc, e.t + 2 + e.gap);
                        exp_data = hist[e.t + 1 + e.gap];
                        nbeats = e.n;
                        idx = 0;
                        active = 1;
                    end
                end
                if (active) begin
                    chk("out_data", bus.out_data, exp_data);
                    chk("out_last", bus.out_last, idx == nbeats - 1);
                    if (ready) begin
                        idx++;
                        mcount++;
                        mcsum ^= exp_data;
                        exp_data = hist[cyc];
                        if (idx == nbeats) active = 0;
                    end
                end
            end else if (active) chk("burst_bubble", bus.out_valid, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rand_vect = {$urandom, $urandom};
        if (fix_on) rand_vect[DW-1:0] = fix_val;
        case (rmode)
            0: ready = 1'b1;
            1: ready = 1'($urandom % 2);
            2: if (idx == 1 && stall < 3) begin ready = 1'b0; stall++; end else ready = 1'b1;
            default: ready = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        enable = 1'b0;
        step();
        reset = 1'b0;
        issued = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && (sb.size() != 0 || active); k++) step();
        chk("idle_reached", sb.size() != 0 || active, 0);
    endtask

    task automatic issue(input int g, input int b);
        int nb;
        wait_idle();
        step();
        rand_vect[DW+:4] = 4'(g);
        rand_vect[DW+4+:3] = 3'(b);
        enable = 1'b1;
        nb = b + 1;
        if (nb > NT - issued) nb = NT - issued;
        if (nb > 0) sb.push_back(exp_t'{cyc, g, nb});
        issued += nb;
        step();
        enable = 1'b0;
    endtask

    task automatic settle_check(input string name, input int cnt, input bit dn);
        step();
        @(negedge clk);
        chk({name, "_count"}, txn_count, cnt);
        chk({name, "_done"}, done, dn);
        chk({name, "_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();
        settle_check("reset", 0, 0);
        fix_on = 1;
        fix_val = 32'hA5;
        rmode = 0;
        issue(0, 0);
        wait_idle();
        settle_check("t1", 1, 0);
        fix_on = 0;
        do_reset();
        issue(5, 3);
        wait_idle();
        settle_check("t2", 4, 0);
        do_reset();
        rmode = 2;
        stall = 0;
        issue(int'($urandom % 16), 2);
        wait_idle();
        settle_check("t3", 3, 0);
        do_reset();
        rmode = 1;
        issue(int'($urandom % 16), 7);
        wait_idle();
        settle_check("t4", 5, 1);
        rmode = 0;
        issue(3, 7);
        repeat (25) step();
        settle_check("t4_ignored", 5, 1);
        do_reset();
        issue(0, 1);
        wait_idle();
        rmode = 3;
        issue(2, 3);
        for (int k = 0; k < 40 && !bus.out_valid; k++) step();
        chk("t5_valid_seen", bus.out_valid, 1);
        chk("t5_ready_low", ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        issued = 0;
        @(negedge clk);
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_count", txn_count, 0);
        chk("t5_done", done, 0);
        for (int i = 0; i < 60; i++) begin
            if (issued == NT) begin
                wait_idle();
                settle_check("rand_cap", NT, 1);
                do_reset();
            end
            rmode = int'($urandom % 2);
            issue(int'($urandom % 16), int'($urandom % 8));
            if ($urandom % 8 == 0) begin
                repeat ($urandom % 12) step();
                do_reset();
            end
        end
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
